accum_bank: RTL and testbench
=============================

ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 Parameter NUM_CH, default SUPER_SYS_COLS/4, number of independent accumulation channels.
REQ-002 Parameter LANES, default 4, partial-sum lanes per channel row.
REQ-003 Parameter DEPTH, default 16, rows per channel buffer (power of two, >=2).
REQ-004 Parameter P_W, default P_BITWIDTH, signed lane width; row width RW = LANES*P_W.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 valid  input  NUM_CH  per-channel write beat qualifier.
REQ-008 overwrite  input  1  1: beat writes row; 0: beat adds into row.
REQ-009 store  input  1  end-of-pass pulse, all channels.
REQ-010 flush  input  1  sampled with store; marks final pass, channel becomes readable.
REQ-011 i_data  input  NUM_CH x LANES x P_W  per-channel partial sums.
REQ-012 rd_en  input  NUM_CH  per-channel pop request.
REQ-013 o_data  output  NUM_CH x RW  popped row, registered.
REQ-014 o_valid  output  NUM_CH  o_data qualifier, one cycle per accepted pop.
REQ-015 empty  output  NUM_CH  1 when channel holds no readable row.
REQ-016 err  output  NUM_CH  sticky protocol/overflow flag.

Function
REQ-017 Each channel SHALL run FSM IDLE -> FILL -> ACC -> DRAIN -> IDLE, independent per channel except shared store/flush.
REQ-018 IDLE: valid with overwrite=1 SHALL write row 0, advance wr_ptr, enter FILL; valid with overwrite=0 SHALL be dropped and set err.
REQ-019 FILL: each valid beat SHALL write i_data to row wr_ptr, wr_ptr+1; store SHALL latch rows=wr_ptr, clear wr_ptr, enter ACC (DRAIN if flush=1).
REQ-020 ACC: each valid beat SHALL add i_data lane-wise into row wr_ptr, wr_ptr+1; store SHALL clear wr_ptr, stay ACC, or enter DRAIN if flush=1.
REQ-021 ACC beat with overwrite=1 SHALL write instead of add (re-fill of that row).
REQ-022 Beat when wr_ptr==DEPTH (FILL) or wr_ptr==rows (ACC) SHALL be dropped and set err.
REQ-023 Lane add SHALL be P_W-bit signed; behaviour on overflow per REQ-033/034.
REQ-024 Beat coincident with store SHALL be applied to the current pass before wr_ptr clears.
REQ-025 DRAIN: empty=0 while rd_ptr<rows; rd_en SHALL pop row rd_ptr, o_data/o_valid valid next cycle, rd_ptr+1.
REQ-026 After last pop, channel SHALL return to IDLE with empty=1 the cycle after the pop.
REQ-027 rd_en while empty SHALL be ignored (o_valid=0, no err); valid during DRAIN SHALL be dropped and set err.
REQ-028 store with zero beats in FILL SHALL give rows=0; with flush the channel SHALL go directly to IDLE.
REQ-029 o_data SHALL hold its last value when o_valid=0.

Reset
REQ-030 rst SHALL set all FSMs IDLE, wr_ptr/rd_ptr/rows=0, o_valid=0, o_data=0, empty=all ones, err=0.
REQ-031 rst mid-pass or mid-drain SHALL abandon data; buffer contents need not be cleared.
REQ-032 err SHALL clear only on rst.

Configuration
REQ-033 With ACCUM_BANK_SAT_EN defined, lane add SHALL saturate to signed P_W max/min.
REQ-034 Without ACCUM_BANK_SAT_EN, lane add SHALL wrap modulo 2^P_W.

Structure
REQ-035 SUPER_SYS_COLS, P_BITWIDTH and the channel-state enum SHALL live in package Config.
REQ-036 One sub-module acc_chan SHALL implement a single channel (FSM, pointers, storage, adder); accum_bank SHALL instantiate NUM_CH of them in a generate loop.

Verification
REQ-037 Fill 4 rows (lane values 1..4), store, 2 accumulate passes of +1, store+flush, pop 4 -> rows 3..6 per lane, o_valid 1 cycle after each rd_en, empty=1 after 4th pop.
REQ-038 P_W=8, fill 100, accumulate 100 -> 127 with ACCUM_BANK_SAT_EN, -56 without.
REQ-039 17 beats in FILL with DEPTH=16 -> 17th dropped, err=1, rows=16.
REQ-040 ACC beat with overwrite=0 in IDLE, and valid in DRAIN -> err=1, data unchanged.
REQ-041 Channel 0 draining while channel 1 filling; rd_en on empty channel 2 -> no o_valid on 2, channels 0/1 independent.
REQ-042 rst asserted mid-ACC pass -> next cycle empty=all ones, o_valid=0, err=0; new fill works normally.

Source files
------------

// File: rtl/accum_bank_pkg.sv
//==============================================================================
// Module      : Config (package)
// Description : Shared sizing constants and per-channel state encoding for
//               the accum_bank accumulation buffer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package Config;

    localparam int SUPER_SYS_COLS = 16;
    localparam int P_BITWIDTH     = 16;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_FILL  = 2'd1,
        CH_ACC   = 2'd2,
        CH_DRAIN = 2'd3
    } chan_state_t;

endpackage

`default_nettype wire

// File: rtl/accum_bank_chan.sv
//==============================================================================
// Module      : acc_chan
// Description : One accumulation channel: fill/accumulate/drain FSM, pointers,
//               row storage and lane-wise adder. ACCUM_BANK_SAT_EN selects
//               saturating lane adds; undefined, lane adds wrap.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module acc_chan
    import Config::*;
#(
    parameter int LANES = 4,
    parameter int DEPTH = 16,
    parameter int P_W   = P_BITWIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid,
    input  logic                       overwrite,
    input  logic                       store,
    input  logic                       flush,
    input  logic [LANES-1:0][P_W-1:0]  i_data,
    input  logic                       rd_en,
    output logic [LANES*P_W-1:0]       o_data,
    output logic                       o_valid,
    output logic                       empty,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);

    chan_state_t r_state;
    chan_state_t w_state_nxt;

    logic [LANES-1:0][P_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [PW-1:0]             r_rows;
    logic [LANES*P_W-1:0]      r_o_data;
    logic                      r_o_valid;
    logic                      r_err;

    logic                      w_beat_ok;
    logic                      w_beat_err;
    logic                      w_pop;
    logic                      w_last_pop;
    logic [PW-1:0]             w_wr_inc;
    logic [PW-1:0]             w_fill_rows;
    logic [LANES-1:0][P_W-1:0] w_cur_row;
    logic [LANES-1:0][P_W-1:0] w_sum;
    logic [LANES-1:0][P_W-1:0] w_wr_data;

    assign w_wr_inc  = r_wr_ptr + 1'b1;
    assign w_cur_row = r_mem[r_wr_ptr[AW-1:0]];

    always_comb begin
        w_beat_ok = 1'b0;
        case (r_state)
            CH_IDLE: w_beat_ok = valid & overwrite;
            CH_FILL: w_beat_ok = valid & (r_wr_ptr != C_DEPTH);
            CH_ACC:  w_beat_ok = valid & (r_wr_ptr < r_rows);
            default: w_beat_ok = 1'b0;
        endcase
    end

    assign w_beat_err  = valid & ~w_beat_ok;
    assign w_pop       = (r_state == CH_DRAIN) & rd_en & (r_rd_ptr < r_rows);
    assign w_last_pop  = w_pop & ((r_rd_ptr + 1'b1) == r_rows);
    // A beat coincident with store still counts toward this pass's row total.
    assign w_fill_rows = w_beat_ok ? w_wr_inc : r_wr_ptr;
    assign w_wr_data   = ((r_state == CH_ACC) && !overwrite) ? w_sum : i_data;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [P_W-1:0] w_a;
        logic [P_W-1:0] w_b;
        logic [P_W-1:0] w_s;
        assign w_a = w_cur_row[l];
        assign w_b = i_data[l];
        assign w_s = w_a + w_b;
`ifdef ACCUM_BANK_SAT_EN
        localparam logic [P_W-1:0] C_MAX = {1'b0, {(P_W-1){1'b1}}};
        localparam logic [P_W-1:0] C_MIN = {1'b1, {(P_W-1){1'b0}}};
        logic w_ovf;
        assign w_ovf    = (w_a[P_W-1] == w_b[P_W-1]) && (w_s[P_W-1] != w_a[P_W-1]);
        assign w_sum[l] = w_ovf ? (w_a[P_W-1] ? C_MIN : C_MAX) : w_s;
`else
        assign w_sum[l] = w_s;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= CH_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CH_IDLE: begin
                if (w_beat_ok && store) w_state_nxt = flush ? CH_DRAIN : CH_ACC;
                else if (w_beat_ok)     w_state_nxt = CH_FILL;
            end
            CH_FILL: begin
                if (store) begin
                    if (!flush)                 w_state_nxt = CH_ACC;
                    else if (w_fill_rows == '0) w_state_nxt = CH_IDLE;
                    else                        w_state_nxt = CH_DRAIN;
                end
            end
            CH_ACC: begin
                if (store && flush) w_state_nxt = (r_rows == '0) ? CH_IDLE : CH_DRAIN;
            end
            CH_DRAIN: begin
                if (w_last_pop) w_state_nxt = CH_IDLE;
            end
            default: w_state_nxt = CH_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        empty = 1'b1;
        if (r_state == CH_DRAIN) empty = (r_rd_ptr >= r_rows);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rows    <= '0;
            r_o_data  <= '0;
            r_o_valid <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_o_valid <= w_pop;
            if (w_pop) r_o_data <= r_mem[r_rd_ptr[AW-1:0]];
            if (w_beat_err) r_err <= 1'b1;

            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            else if (store && r_state != CH_DRAIN) r_rd_ptr <= '0;

            case (r_state)
                CH_IDLE, CH_FILL: begin
                    if (store) begin
                        r_rows   <= w_fill_rows;
                        r_wr_ptr <= '0;
                    end else if (w_beat_ok) begin
                        r_wr_ptr <= w_wr_inc;
                    end
                end
                CH_ACC: begin
                    if (store)          r_wr_ptr <= '0;
                    else if (w_beat_ok) r_wr_ptr <= w_wr_inc;
                end
                default: r_wr_ptr <= '0;
            endcase
        end
    end

    // Row storage carries no reset; every row is written before it is read.
    always_ff @(posedge clk) begin
        if (w_beat_ok) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
    end

    assign o_data  = r_o_data;
    assign o_valid = r_o_valid;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: rtl/accum_bank.sv
//==============================================================================
// Module      : accum_bank
// Description : Bank of NUM_CH independent row accumulators sharing store and
//               flush. ACCUM_BANK_SAT_EN selects saturating lane adds.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module accum_bank
    import Config::*;
#(
    parameter int NUM_CH = SUPER_SYS_COLS / 4,
    parameter int LANES  = 4,
    parameter int DEPTH  = 16,
    parameter int P_W    = P_BITWIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CH-1:0]                     valid,
    input  logic                                  overwrite,
    input  logic                                  store,
    input  logic                                  flush,
    input  logic [NUM_CH-1:0][LANES-1:0][P_W-1:0] i_data,
    input  logic [NUM_CH-1:0]                     rd_en,
    output logic [NUM_CH-1:0][LANES*P_W-1:0]      o_data,
    output logic [NUM_CH-1:0]                     o_valid,
    output logic [NUM_CH-1:0]                     empty,
    output logic [NUM_CH-1:0]                     err
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        acc_chan #(
            .LANES (LANES),
            .DEPTH (DEPTH),
            .P_W   (P_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .valid     (valid[c]),
            .overwrite (overwrite),
            .store     (store),
            .flush     (flush),
            .i_data    (i_data[c]),
            .rd_en     (rd_en[c]),
            .o_data    (o_data[c]),
            .o_valid   (o_valid[c]),
            .empty     (empty[c]),
            .err       (err[c])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_accum_bank.sv
//==============================================================================
// Module      : tb_accum_bank
// Description : Randomized and directed self-checking bench for accum_bank
//               against a row/pass-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_accum_bank;

    localparam int NUM_CH = 4;
    localparam int LANES  = 4;
    localparam int DEPTH  = 16;
    localparam int P_W    = 8;
    localparam int RW     = LANES * P_W;
    localparam int VMAX   = (1 << (P_W - 1)) - 1;
    localparam int VMIN   = -(1 << (P_W - 1));

    localparam int M_IDLE = 0, M_FILL = 1, M_ACC = 2, M_DRAIN = 3;

    logic                                  clk = 1'b0;
    logic                                  rst;
    logic [NUM_CH-1:0]                     valid;
    logic                                  overwrite, store, flush;
    logic [NUM_CH-1:0][LANES-1:0][P_W-1:0] i_data;
    logic [NUM_CH-1:0]                     rd_en;
    logic [NUM_CH-1:0][RW-1:0]             o_data;
    logic [NUM_CH-1:0]                     o_valid, empty, err;

    accum_bank #(.NUM_CH(NUM_CH), .LANES(LANES), .DEPTH(DEPTH), .P_W(P_W)) dut (
        .clk(clk), .rst(rst), .valid(valid), .overwrite(overwrite), .store(store),
        .flush(flush), .i_data(i_data), .rd_en(rd_en), .o_data(o_data),
        .o_valid(o_valid), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per channel, a phase, a table of integer lane values
    // and the row counts of the current pass.
    int          m_mode [NUM_CH];
    int          m_mem  [NUM_CH][DEPTH][LANES];
    int          m_rows [NUM_CH];
    int          m_wptr [NUM_CH];
    int          m_rptr [NUM_CH];
    bit          m_err  [NUM_CH];
    bit          m_ov   [NUM_CH];
    logic [RW-1:0] m_od [NUM_CH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic int lane_add(input int a, input int b);
        int s;
        s = a + b;
`ifdef ACCUM_BANK_SAT_EN
        if (s > VMAX) s = VMAX;
        if (s < VMIN) s = VMIN;
`else
        s = ((s - VMIN) % (1 << P_W) + (1 << P_W)) % (1 << P_W) + VMIN;
`endif
        return s;
    endfunction

    function automatic logic [RW-1:0] pack_row(input int c, input int r);
        logic [RW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*P_W +: P_W] = P_W'(m_mem[c][r][l]);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = M_IDLE; m_rows[c] = 0; m_wptr[c] = 0; m_rptr[c] = 0;
            m_err[c] = 0; m_ov[c] = 0; m_od[c] = '0;
        end
    endtask

    task automatic model_write(input int c, input bit add);
        for (int l = 0; l < LANES; l++) begin
            int d;
            d = int'($signed(i_data[c][l]));
            m_mem[c][m_wptr[c]][l] = add ? lane_add(m_mem[c][m_wptr[c]][l], d) : d;
        end
        m_wptr[c]++;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            int m0;
            m0 = m_mode[c];
            m_ov[c] = 0;
            if (m0 == M_DRAIN && rd_en[c] && m_rptr[c] < m_rows[c]) begin
                m_od[c] = pack_row(c, m_rptr[c]);
                m_ov[c] = 1;
                m_rptr[c]++;
                if (m_rptr[c] == m_rows[c]) m_mode[c] = M_IDLE;
            end
            if (valid[c]) begin
                case (m0)
                    M_IDLE:  if (overwrite) begin model_write(c, 0); m_mode[c] = M_FILL; end
                             else m_err[c] = 1;
                    M_FILL:  if (m_wptr[c] < DEPTH) model_write(c, 0); else m_err[c] = 1;
                    M_ACC:   if (m_wptr[c] < m_rows[c]) model_write(c, !overwrite); else m_err[c] = 1;
                    default: m_err[c] = 1;
                endcase
            end
            if (store && m0 != M_DRAIN) begin
                if (m_mode[c] == M_FILL) begin
                    m_rows[c] = m_wptr[c];
                    m_wptr[c] = 0; m_rptr[c] = 0;
                    m_mode[c] = !flush ? M_ACC : (m_rows[c] == 0 ? M_IDLE : M_DRAIN);
                end else if (m_mode[c] == M_ACC) begin
                    m_wptr[c] = 0; m_rptr[c] = 0;
                    if (flush) m_mode[c] = (m_rows[c] == 0) ? M_IDLE : M_DRAIN;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("o_valid[%0d]", c), 64'(o_valid[c]), 64'(m_ov[c]));
            chk($sformatf("o_data[%0d]", c), 64'(o_data[c]), 64'(m_od[c]));
            chk($sformatf("empty[%0d]", c), 64'(empty[c]),
                64'(!(m_mode[c] == M_DRAIN && m_rptr[c] < m_rows[c])));
            chk($sformatf("err[%0d]", c), 64'(err[c]), 64'(m_err[c]));
        end
    endtask

    task automatic beat(input logic [NUM_CH-1:0] m, input logic ow, input int v);
        valid = m; overwrite = ow;
        for (int c = 0; c < NUM_CH; c++) i_data[c] = {LANES{P_W'(v)}};
        tick();
        valid = '0; overwrite = 1'b0;
    endtask

    task automatic do_store(input logic f);
        store = 1'b1; flush = f;
        tick();
        store = 1'b0; flush = 1'b0;
    endtask

    task automatic pop(input logic [NUM_CH-1:0] m);
        rd_en = m;
        tick();
        rd_en = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [P_W-1:0] lane0;
        rst = 1'b1; valid = '0; overwrite = 1'b0; store = 1'b0; flush = 1'b0;
        i_data = '0; rd_en = '0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk("reset_empty", 64'(empty), 64'({NUM_CH{1'b1}}));
        chk("reset_err", 64'(err), 64'(0));

        // Accumulate beat into an idle channel is a protocol error.
        beat(4'b1000, 1'b0, 5);
        chk("idle_add_err", 64'(err[3]), 64'(1));

        // Fill 4 rows, two +1 passes, flush, drain: rows read 3..6.
        for (int r = 0; r < 4; r++) beat(4'b0001, 1'b1, r + 1);
        do_store(1'b0);
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 4; r++) beat(4'b0001, 1'b0, 1);
            do_store(p == 1);
        end
        for (int r = 0; r < 4; r++) begin
            pop(4'b0001);
            chk("drain_row", 64'(o_data[0][P_W-1:0]), 64'(r + 3));
        end
        chk("drain_done_empty", 64'(empty[0]), 64'(1));

        // Lane overflow: 100 + 100 saturates or wraps.
        beat(4'b0010, 1'b1, 100);
        do_store(1'b0);
        beat(4'b0010, 1'b0, 100);
        do_store(1'b1);
        pop(4'b0010);
        lane0 = o_data[1][P_W-1:0];
`ifdef ACCUM_BANK_SAT_EN
        chk("overflow_lane", 64'(lane0), 64'(8'd127));
`else
        chk("overflow_lane", 64'(lane0), 64'(8'hC8));
`endif

        // 17 beats into a 16-deep buffer; then a beat during drain.
        for (int r = 0; r < 17; r++) beat(4'b0100, 1'b1, r);
        chk("overfill_err", 64'(err[2]), 64'(1));
        do_store(1'b1);
        beat(4'b0100, 1'b1, 99);
        for (int r = 0; r < 16; r++) pop(4'b0100);
        chk("overfill_rows_drained", 64'(empty[2]), 64'(1));

        // Channel 0 drains while channel 1 fills; channel 2 popped while empty.
        do_reset();
        beat(4'b0001, 1'b1, 7);
        beat(4'b0001, 1'b1, 8);
        do_store(1'b1);
        for (int k = 0; k < 2; k++) begin
            valid = 4'b0010; overwrite = 1'b1;
            i_data[1] = {LANES{P_W'(20 + k)}};
            pop(4'b0101);
            valid = '0; overwrite = 1'b0;
            chk("empty_chan_no_valid", 64'(o_valid[2]), 64'(0));
        end

        // Reset in the middle of an accumulate pass.
        do_store(1'b0);
        beat(4'b0010, 1'b0, 3);
        do_reset();
        chk("midpass_rst_empty", 64'(empty), 64'({NUM_CH{1'b1}}));
        chk("midpass_rst_err", 64'(err), 64'(0));
        chk("midpass_rst_ovalid", 64'(o_valid), 64'(0));
        beat(4'b0010, 1'b1, 42);
        do_store(1'b1);
        pop(4'b0010);
        chk("post_rst_refill", 64'(o_data[1][P_W-1:0]), 64'(42));

        // Randomized traffic on all channels.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 399) == 0);
            store     = ($urandom_range(0, 11) == 0);
            flush     = store && ($urandom_range(0, 2) == 0);
            overwrite = ($urandom_range(0, 2) == 0);
            valid     = NUM_CH'($urandom);
            rd_en     = NUM_CH'($urandom);
            for (int c = 0; c < NUM_CH; c++)
                for (int l = 0; l < LANES; l++) i_data[c][l] = P_W'($urandom);
            tick();
        end
        rst = 1'b0; valid = '0; store = 1'b0; flush = 1'b0; rd_en = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
